// File: rtl/v_hier_pkg.sv
// Shared types and widths for the v_hier example hierarchy.
package v_hier_pkg;

    localparam int NIB_W = 4;
    localparam int CNT_W = 16;

    // Transmitter frame sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/v_hier_src_shift.sv
// Loadable right-shift-by-nibble register with a running XOR of every
// nibble it has handed out. On load the lowest nibble is taken as already
// consumed: it seeds the accumulator and the register holds the remainder,
// so `nibble` always presents the next nibble still to be sent.
module v_hier_src_shift
    import v_hier_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic [NIB_W-1:0]  nibble,
    output logic [NIB_W-1:0]  check
);

    logic [DATA_W-1:0] sr;
    logic [NIB_W-1:0]  chk;

    assign nibble = sr[NIB_W-1:0];
    assign check  = chk;

    // Load a new word or step one nibble, folding the outgoing nibble into the XOR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            chk <= '0;
        end else if (load) begin
            sr  <= data >> NIB_W;
            chk <= data[NIB_W-1:0];
        end else if (shift) begin
            sr  <= sr >> NIB_W;
            chk <= chk ^ sr[NIB_W-1:0];
        end
    end

endmodule

// File: rtl/v_hier_src.sv
// Nibble-stream transmitter: accepts a word, sends it LSB nibble first,
// then an XOR check nibble flagged with avec_last, then GAP idle cycles.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both 1. in_valid/in_data are ignored while in_ready is 0. The output
// side has no ready: every cycle with avec_valid=1 is a beat the consumer
// must take, and avec reads 0 whenever avec_valid is 0.
module v_hier_src
    import v_hier_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        avec,
    output logic              avec_valid,
    output logic              avec_last,
    output logic              busy,
    output logic [15:0]       tx_count
);

    localparam int NIB  = DATA_W / NIB_W;
    localparam int BC_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t            state;
    logic [BC_W-1:0]   beat_cnt;
    logic [3:0]        gap_cnt;
    logic              accept;
    logic              last_data;
    logic              shift;
    logic [NIB_W-1:0]  nibble;
    logic [NIB_W-1:0]  check;

    // Ready in IDLE, and during the check beat when no gap follows so frames
    // can run back to back. Held low while reset is applied.
    assign in_ready  = !rst && ((state == IDLE) || ((GAP == 0) && (state == CHK)));
    assign accept    = in_valid && in_ready;
    assign last_data = (beat_cnt == BC_W'(NIB - 1));
    assign shift     = (state == SEND) && !last_data;
    assign busy      = (state != IDLE);

    v_hier_src_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (shift),
        .data   (in_data),
        .nibble (nibble),
        .check  (check)
    );

    // Frame sequencer with registered beat outputs and completed-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            avec       <= '0;
            avec_valid <= 1'b0;
            avec_last  <= 1'b0;
            tx_count   <= '0;
        end else begin
            avec       <= '0;
            avec_valid <= 1'b0;
            avec_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SEND;
                        beat_cnt   <= '0;
                        avec       <= in_data[NIB_W-1:0];
                        avec_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (last_data) begin
                        state      <= CHK;
                        avec       <= check;
                        avec_valid <= 1'b1;
                        avec_last  <= 1'b1;
                    end else begin
                        beat_cnt   <= beat_cnt + 1'b1;
                        avec       <= nibble;
                        avec_valid <= 1'b1;
                    end
                end
                CHK: begin
                    tx_count <= tx_count + 1'b1;
                    if (GAP == 0) begin
                        if (accept) begin
                            state      <= SEND;
                            beat_cnt   <= '0;
                            avec       <= in_data[NIB_W-1:0];
                            avec_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state   <= WAIT;
                        gap_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (gap_cnt == 4'(GAP - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v_hier_src.sv
// Directed bench for v_hier_src: an 8-bit/GAP=1 instance and a
// 16-bit/GAP=0 instance share clock and reset.
module tb_v_hier_src;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT 8-bit, GAP=1 ----------------
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic [3:0]  avec8;
    logic        avec_valid8;
    logic        avec_last8;
    logic        busy8;
    logic [15:0] tx_count8;

    v_hier_src #(.DATA_W(8), .GAP(1)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .in_data    (in_data8),
        .avec       (avec8),
        .avec_valid (avec_valid8),
        .avec_last  (avec_last8),
        .busy       (busy8),
        .tx_count   (tx_count8)
    );

    // ---------------- DUT 16-bit, GAP=0 ----------------
    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] in_data16;
    logic [3:0]  avec16;
    logic        avec_valid16;
    logic        avec_last16;
    logic        busy16;
    logic [15:0] tx_count16;

    v_hier_src #(.DATA_W(16), .GAP(0)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid16),
        .in_ready   (in_ready16),
        .in_data    (in_data16),
        .avec       (avec16),
        .avec_valid (avec_valid16),
        .avec_last  (avec_last16),
        .busy       (busy16),
        .tx_count   (tx_count16)
    );

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic       last_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (DUT 8) ----------------
    // Offer one word and check its three beats; optionally scramble in_data mid-frame.
    task automatic send8(input logic [7:0] data, input logic [3:0] e0, input logic [3:0] e1,
                         input logic [3:0] e2, input bit toggle);
        check_eq("rdy8_before_send", 32'(in_ready8), 32'd1);
        in_valid8 = 1'b1;
        in_data8  = data;
        exp_q  = '{e0, e1, e2};
        last_q = '{1'b0, 1'b0, 1'b1};
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in_valid8 = 1'b0;
            if (toggle) in_data8 = 8'($urandom_range(0, 255));
            check_eq("avec8", 32'(avec8), 32'(exp_q.pop_front()));
            check_eq("avec_valid8", 32'(avec_valid8), 32'd1);
            check_eq("avec_last8", 32'(avec_last8), 32'(last_q.pop_front()));
            check_eq("busy8_in_frame", 32'(busy8), 32'd1);
        end
    endtask

    // Wait (bounded) until in_ready8 returns; report how many more cycles it stayed low.
    task automatic wait_ready8(output int low_cycles);
        low_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready8) return;
            check_eq("avec_valid8_gap", 32'(avec_valid8), 32'd0);
            check_eq("avec8_gap", 32'(avec8), 32'd0);
            low_cycles++;
        end
        check_eq("wait_ready8_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int low;
        logic [3:0] e16[10];
        logic       l16[10];

        rst        = 1'b1;
        in_valid8  = 1'b0;
        in_data8   = '0;
        in_valid16 = 1'b0;
        in_data16  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready8", 32'(in_ready8), 32'd0);
        check_eq("rst_in_ready16", 32'(in_ready16), 32'd0);
        check_eq("rst_avec_valid8", 32'(avec_valid8), 32'd0);
        check_eq("rst_avec_last8", 32'(avec_last8), 32'd0);
        check_eq("rst_avec8", 32'(avec8), 32'd0);
        check_eq("rst_tx_count8", 32'(tx_count8), 32'd0);
        check_eq("rst_busy8", 32'(busy8), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready8", 32'(in_ready8), 32'd1);
        check_eq("post_rst_in_ready16", 32'(in_ready16), 32'd1);

        // Idle for 10 cycles with no valid
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_avec_valid8", 32'(avec_valid8), 32'd0);
            check_eq("idle_avec8", 32'(avec8), 32'd0);
            check_eq("idle_busy8", 32'(busy8), 32'd0);
            check_eq("idle_avec_valid16", 32'(avec_valid16), 32'd0);
            check_eq("idle_busy16", 32'(busy16), 32'd0);
        end

        // 0xA5 -> 5, A, F; in_ready low for 4 cycles (3 beats + 1 gap)
        send8(8'hA5, 4'h5, 4'hA, 4'hF, 1'b0);
        wait_ready8(low);
        check_eq("a5_ready_low_cycles", 32'(3 + low), 32'd4);
        check_eq("a5_busy_after", 32'(busy8), 32'd0);
        check_eq("a5_tx_count", 32'(tx_count8), 32'd1);

        // 0x96 with in_data scrambled mid-frame -> 6, 9, F
        send8(8'h96, 4'h6, 4'h9, 4'hF, 1'b1);
        wait_ready8(low);
        check_eq("toggle_tx_count", 32'(tx_count8), 32'd2);

        // Reset on the second beat of 0xA5
        in_valid8 = 1'b1;
        in_data8  = 8'hA5;
        @(negedge clk);
        in_valid8 = 1'b0;
        check_eq("abort_beat0", 32'(avec8), 32'h5);
        @(negedge clk);
        check_eq("abort_beat1", 32'(avec8), 32'hA);
        rst = 1'b1;
        #1;
        check_eq("abort_avec_valid8", 32'(avec_valid8), 32'd0);
        check_eq("abort_avec_last8", 32'(avec_last8), 32'd0);
        check_eq("abort_avec8", 32'(avec8), 32'd0);
        check_eq("abort_busy8", 32'(busy8), 32'd0);
        check_eq("abort_in_ready8", 32'(in_ready8), 32'd0);
        check_eq("abort_tx_count8", 32'(tx_count8), 32'd0);
        @(negedge clk);
        check_eq("abort_no_last", 32'(avec_last8), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("abort_release_ready", 32'(in_ready8), 32'd1);
        send8(8'h3C, 4'hC, 4'h3, 4'hF, 1'b0);
        wait_ready8(low);
        check_eq("fresh_tx_count", 32'(tx_count8), 32'd1);

        // Counter wrap: preload 0xFFFF, one more frame wraps to 0
        force u_dut8.tx_count = 16'hFFFF;
        #1;
        release u_dut8.tx_count;
        #1;
        check_eq("wrap_preload", 32'(tx_count8), 32'hFFFF);
        send8(8'h00, 4'h0, 4'h0, 4'h0, 1'b0);
        wait_ready8(low);
        check_eq("wrap_tx_count", 32'(tx_count8), 32'h0000);

        // 16-bit, GAP=0: 0x1234 then 0xFFFF back to back
        e16 = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        l16 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(e16[i]);
            last_q.push_back(l16[i]);
        end
        in_valid16 = 1'b1;
        in_data16  = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) in_data16 = 16'hFFFF;
            if (i == 8) in_valid16 = 1'b0;
            check_eq("avec16", 32'(avec16), 32'(exp_q.pop_front()));
            check_eq("avec_valid16", 32'(avec_valid16), 32'd1);
            check_eq("avec_last16", 32'(avec_last16), 32'(last_q.pop_front()));
            if (i == 4) check_eq("b2b_ready_in_chk", 32'(in_ready16), 32'd1);
            if (i == 1) check_eq("b2b_ready_in_send", 32'(in_ready16), 32'd0);
        end
        @(negedge clk);
        check_eq("b2b_done_valid", 32'(avec_valid16), 32'd0);
        check_eq("b2b_done_avec", 32'(avec16), 32'd0);
        check_eq("b2b_done_busy", 32'(busy16), 32'd0);
        check_eq("b2b_tx_count", 32'(tx_count16), 32'd2);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
